// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes
// and the exception handler address.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_LO    = 10;
  localparam int EXC_LO   = 2;
  localparam int CAUSE_BD = 31;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational arbitration between hardware interrupts and the synchronous
// exception carried by the instruction in M; interrupts win.
module cp0_req_gen
  import cp0_pkg::*;
#(
  parameter int INT_W = 6
) (
  input  logic             reset,
  input  logic             ie,
  input  logic             exl,
  input  logic [INT_W-1:0] im,
  input  logic [INT_W-1:0] hw_int,
  input  logic [4:0]       exc_code,
  output logic             req,
  output logic [4:0]       sel_code
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req  = ie & ~exl & (|(hw_int & im));
    exc_req  = ~exl & (exc_code != 5'd0);
    req      = ~reset & (int_req | exc_req);
    sel_code = int_req ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId, mtc0/mfc0/eret, and the
// pipeline-wide exception/interrupt request.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID  = 32'h2023_0007,
  parameter int          INT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  output logic [31:0]      cp0_rdata,
  input  logic [31:0]      m_pc,
  input  logic             m_delaySlot,
  input  logic [4:0]       m_excCode,
  input  logic             m_eret,
  input  logic [INT_W-1:0] hw_int,
  output logic             req,
  output logic [31:0]      epc_out
);

  logic             ie;
  logic             exl;
  logic [INT_W-1:0] im;
  logic [INT_W-1:0] ip;
  logic             bd;
  logic [4:0]       exc_code;
  logic [31:0]      epc;
  logic [4:0]       sel_code;
  logic [31:0]      sr_val;
  logic [31:0]      cause_val;

  cp0_req_gen #(.INT_W(INT_W)) u_req_gen (
    .reset    (reset),
    .ie       (ie),
    .exl      (exl),
    .im       (im),
    .hw_int   (hw_int),
    .exc_code (m_excCode),
    .req      (req),
    .sel_code (sel_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      ip       <= '0;
      bd       <= 1'b0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= hw_int;
      if (req) begin
        // The excepted instruction's own mtc0/eret is dropped.
        exl      <= 1'b1;
        exc_code <= sel_code;
        bd       <= m_delaySlot;
        epc      <= m_delaySlot ? (m_pc - 32'd4) : m_pc;
      end else begin
        if (en && (cp0_addr == REG_SR)) begin
          im  <= cp0_wdata[IM_LO +: INT_W];
          exl <= cp0_wdata[SR_EXL];
          ie  <= cp0_wdata[SR_IE];
        end
        if (en && (cp0_addr == REG_EPC)) begin
          epc <= cp0_wdata;
        end
        // Placed after the SR write so eret's EXL clear overrides it.
        if (m_eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_val                     = 32'd0;
    sr_val[IM_LO +: INT_W]     = im;
    sr_val[SR_EXL]             = exl;
    sr_val[SR_IE]              = ie;
    cause_val                  = 32'd0;
    cause_val[CAUSE_BD]        = bd;
    cause_val[IM_LO +: INT_W]  = ip;
    cause_val[EXC_LO +: 5]     = exc_code;
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_val;
      REG_CAUSE: cp0_rdata = cause_val;
      REG_EPC:   cp0_rdata = epc;
      REG_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = 32'd0;
    endcase
    epc_out = epc;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Coprocessor-0 block at the M stage of the five-stage MIPS pipeline. It consumes the exception information carried by the E/M pipeline register: PC, 5-bit ExcCode and the delay-slot flag. It also samples the external hardware interrupt lines. From these it raises the pipeline-wide flush/redirect request `req`, which sends the next fetch to the handler at 0x0000_4180. It maintains the SR, Cause, EPC and PRId registers and serves mtc0/mfc0/eret.

Parameters:
PRID, 32'h2023_0007, constant returned on reads of register 15
INT_W, 6, number of hardware interrupt lines (maps to SR.IM / Cause.IP bits 15:10)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  mtc0 write strobe from M stage
cp0_addr  in  5  CP0 register number for mtc0/mfc0
cp0_wdata  in  32  mtc0 data (forwarded rt value)
cp0_rdata  out  32  mfc0 read data, combinational
m_pc  in  32  PC of the instruction in M; valid during bubbles as well (stall keeps PC)
m_delaySlot  in  1  instruction in M is in a branch delay slot
m_excCode  in  5  pending exception code for the instruction in M; 0 = none
m_eret  in  1  eret is in M
hw_int  in  INT_W  external interrupt lines, level-sensitive
req  out  1  take exception/interrupt this cycle; flushes F/D/E/M regs and redirects PC to 0x4180
epc_out  out  32  current EPC value, for eret redirect

Behaviour:
- Registers and fields:
  - SR(12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): returns PRID.
  - Any other address reads 0.
- Reset (sync): SR=0, Cause=0, EPC=0. `req` is forced 0 while reset is high.
- Request generation (combinational):
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (m_excCode != 0).
  - req = ~reset & (int_req | exc_req).
  - Interrupt has priority over a synchronous exception in the same cycle.
- On posedge with req=1:
  - EXL<=1.
  - Cause.ExcCode <= int_req ? 0 : m_excCode.
  - BD<=m_delaySlot.
  - EPC <= m_delaySlot ? m_pc-4 : m_pc. EPC is stored with bits[1:0] as given (no alignment), so AdEL on fetch records the faulting PC.
- Cause.IP <= hw_int every cycle, independent of req/en/EXL. IP is not writable by mtc0.
- mtc0 (en=1, req=0), written at posedge:
  - addr 12 writes IM, EXL and IE from the corresponding wdata bits.
  - addr 14 writes EPC fully.
  - addr 13, addr 15 and other addresses: write ignored.
- Simultaneous events:
  - req=1 with en=1: the mtc0 write is discarded; the instruction is being excepted.
  - req=1 with m_eret=1: req wins. In practice this cannot occur, because eret executes with EXL=1, which masks both request sources.
  - m_eret=1, req=0: EXL<=0 at posedge; an en write to SR in the same cycle is applied first and then EXL is cleared.
- mfc0 reads return register state before the current edge (no internal bypass). Consecutive mtc0→mfc0 is resolved by the hazard unit stall.
- epc_out = EPC register (no bypass). A mtc0 EPC followed by eret is stalled externally.
- Latency: req is same-cycle combinational; register updates take effect on the next edge.
- EXL=1 masks nested exceptions and interrupts. A nonzero m_excCode under EXL is ignored and causes no state change.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers SR=12, CAUSE=13, EPC=14, PRID=15;
  - bit positions IE=0, EXL=1, IM/IP 15:10, EXC 6:2, BD=31;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12;
  - handler address 32'h0000_4180.
- One natural sub-module: cp0_req_gen, the combinational int/exc arbitration producing req and the selected ExcCode. Register file logic stays in cp0_unit.

Test Plan:
- Reset, then mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 → req=1 that cycle; next cycle SR.EXL=1, Cause=32'h0000_1000, EPC=m_pc.
- m_excCode=12 (Ov), m_delaySlot=1, m_pc=32'h0000_3010, IE=0 → req=1; EPC=32'h0000_300C, Cause.BD=1, Cause.ExcCode=12.
- EXL=1 with m_excCode=10 and hw_int active → req=0; SR, Cause.ExcCode and EPC unchanged; Cause.IP still tracks hw_int.
- Same cycle: hw_int[0] with IM[10]=1, IE=1, and m_excCode=4 → req=1, ExcCode=0 (Int wins), mtc0 with en=1 to EPC discarded.
- m_eret=1 with EXL=1, EPC=32'h0000_3040 → epc_out=32'h0000_3040; next cycle EXL=0. A pending masked interrupt then asserts req the following cycle.
- mfc0 addr 15 → 32'h2023_0007. mfc0 addr 7 → 0. mtc0 addr 13 with 32'hFFFF_FFFF → Cause unchanged except IP.
